// File: rtl/alu_pipe.sv
// Handshaked signed ALU with a registered result, a {V,C,N,Z} flag vector, and an
// iterative shift-add signed multiplier. One beat in flight at a time.
module alu_pipe #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y,
  output logic [3:0]           flags,
  output logic [1:0]           o_dbg_state
);

  localparam int RW = 2 * WIDTH;
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic [RW-1:0]    ONE_R  = RW'(1);
  localparam logic [3:0]       OP_MUL = 4'b0101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: a beat transfers on any rising edge where valid && ready are both
  // high; the producer may drop valid at any time, and the result (y, flags) is
  // held unchanged while out_valid is high and out_ready is low.
  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_is_mul;

  logic [RW-1:0]      r_y;
  logic [3:0]         r_flags;
  logic [RW-1:0]      r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [RW-1:0]      r_acc;
  logic               r_neg;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH-1:0]   w_x;
  logic [WIDTH-1:0]   w_z;
  logic [WIDTH-1:0]   w_zz;
  logic               w_sub;
  logic [WIDTH:0]     w_sum;
  logic               w_c;
  logic               w_v;
  logic [WIDTH-1:0]   w_lg;
  logic [RW-1:0]      w_ext;
  logic [SW-1:0]      w_sh;
  logic [RW-1:0]      w_res;
  logic [3:0]         w_alu_flags;
  logic [WIDTH-1:0]   w_amag;
  logic [WIDTH-1:0]   w_bmag;
  logic [RW-1:0]      w_acc_next;
  logic [RW-1:0]      w_prod;
  logic               w_mv;

  assign w_accept    = in_valid && in_ready;
  assign w_is_mul    = (sel == OP_MUL);
  assign y           = r_y;
  assign flags       = r_flags;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_is_mul ? S_MUL : S_DONE;
      S_MUL:  if (r_cnt == CW'(1)) w_next = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          if (w_accept) w_next = w_is_mul ? S_MUL : S_DONE;
          else          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: in_ready = !rst;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !rst;
      end
      default: ;
    endcase
  end

  // add/sub/inc/dec/neg share one (WIDTH+1)-bit adder: x + (sub ? ~z : z) + sub
  always_comb begin
    w_x   = '0;
    w_z   = '0;
    w_sub = 1'b0;
    case (sel)
      4'b0000: begin w_x = a;  w_z = b;                   end
      4'b0001: begin w_x = a;  w_z = b;     w_sub = 1'b1; end
      4'b0010: begin w_x = a;  w_z = ONE_W;               end
      4'b0011: begin w_x = a;  w_z = ONE_W; w_sub = 1'b1; end
      4'b0100: begin w_x = '0; w_z = a;     w_sub = 1'b1; end
      default: ;
    endcase
  end

  assign w_zz  = w_sub ? ~w_z : w_z;
  assign w_sum = {w_x[WIDTH-1], w_x} + {w_zz[WIDTH-1], w_zz} + (WIDTH+1)'(w_sub);
  // Top bit of the sign-extended sum is msb_x ^ msb_zz ^ unsigned carry-out.
  assign w_c   = w_sum[WIDTH] ^ w_x[WIDTH-1] ^ w_zz[WIDTH-1];
  assign w_v   = w_sum[WIDTH] ^ w_sum[WIDTH-1];
  assign w_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign w_sh  = b[SW-1:0];

  always_comb begin
    w_lg = '0;
    case (sel)
      4'b1000: w_lg = ~a;
      4'b1001: w_lg = ~b;
      4'b1010: w_lg = a & b;
      4'b1011: w_lg = a | b;
      4'b1100: w_lg = a ^ b;
      4'b1101: w_lg = ~(a ^ b);
      4'b1110: w_lg = ~(a & b);
      4'b1111: w_lg = ~(a | b);
      default: ;
    endcase
  end

  always_comb begin
    w_res       = {{WIDTH{w_lg[WIDTH-1]}}, w_lg};
    w_alu_flags = 4'b0000;
    case (sel)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100: begin
        w_res          = {{(WIDTH-1){w_sum[WIDTH]}}, w_sum};
        w_alu_flags[3] = w_v;
        w_alu_flags[2] = w_c;
      end
      4'b0101: w_res = '0;
      4'b0110: w_res = w_ext << w_sh;
      4'b0111: w_res = $signed(w_ext) >>> w_sh;
      default: ;
    endcase
    w_alu_flags[1] = w_res[RW-1];
    w_alu_flags[0] = (w_res == '0);
  end

  // Magnitudes are WIDTH-bit unsigned, so the most negative operand stays exact.
  assign w_amag     = a[WIDTH-1] ? (~a + ONE_W) : a;
  assign w_bmag     = b[WIDTH-1] ? (~b + ONE_W) : b;
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod     = r_neg ? (~w_acc_next + ONE_R) : w_acc_next;
  assign w_mv       = !((&w_prod[RW-1:WIDTH-1]) || !(|w_prod[RW-1:WIDTH-1]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y      <= '0;
      r_flags  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_amag};
        r_mplier <= w_bmag;
        r_acc    <= '0;
        r_neg    <= a[WIDTH-1] ^ b[WIDTH-1];
        r_cnt    <= CW'(WIDTH);
      end else begin
        r_y     <= w_res;
        r_flags <= w_alu_flags;
      end
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_y     <= w_prod;
        r_flags <= {w_mv, 1'b0, w_prod[RW-1], (w_prod == '0)};
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=4): directed vectors with hand-computed results, an
// arithmetic reference model feeding an expected queue, and one compare process.
module tb_alu_pipe;

  localparam int W  = 4;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [3:0]    sel;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] y;
  logic [3:0]    flags;
  logic [1:0]    dbg_state;

  alu_pipe #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .sel         (sel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y           (y),
    .flags       (flags),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;
  logic [RW+3:0] exp_q[$];

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic [3:0] op;
    logic [7:0] ey;
    logic [3:0] ef;
  } vec_t;
  vec_t vt[$];

  // reference model: exact integer arithmetic, then truncate to 2*W bits
  function automatic logic [RW+3:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic [3:0] op);
    int sa, sb, ua, ub, e, sh;
    logic c, v, arith;
    logic [W-1:0] lg;
    logic [RW-1:0] yy;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ua = int'(ma);
    ub = int'(mb);
    sh = ub % W;
    c = 1'b0;
    arith = 1'b1;
    e = 0;
    lg = '0;
    case (op)
      4'h0: begin e = sa + sb; c = (ua + ub) >= (1 << W);    end
      4'h1: begin e = sa - sb; c = (ua >= ub);               end
      4'h2: begin e = sa + 1;  c = (ua == (1 << W) - 1);     end
      4'h3: begin e = sa - 1;  c = (ua >= 1);                end
      4'h4: begin e = -sa;     c = (ua == 0);                end
      4'h5: e = sa * sb;
      4'h6: begin e = sa * (1 << sh); arith = 1'b0; end
      4'h7: begin e = sa >>> sh;      arith = 1'b0; end
      default: begin
        arith = 1'b0;
        case (op)
          4'h8: lg = ~ma;
          4'h9: lg = ~mb;
          4'hA: lg = ma & mb;
          4'hB: lg = ma | mb;
          4'hC: lg = ma ^ mb;
          4'hD: lg = ~(ma ^ mb);
          4'hE: lg = ~(ma & mb);
          default: lg = ~(ma | mb);
        endcase
        e = int'($signed(lg));
      end
    endcase
    v  = arith && ((e > (1 << (W - 1)) - 1) || (e < -(1 << (W - 1))));
    yy = e[RW-1:0];
    return {v, c, yy[RW-1], (yy == '0), yy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // scoreboard compare: every cycle a result is presented
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got y=0x%0h flags=%b, required no result", y, flags);
      end else begin
        if ({flags, y} !== exp_q[0]) begin
          n_err++;
          $display("FAIL result: got flags=%b y=0x%0h, required flags=%b y=0x%0h",
                   flags, y, exp_q[0][RW+3:RW], exp_q[0][RW-1:0]);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_hs++;
        end
      end
    end
  end

  // driver: present one beat, wait (bounded) for acceptance, then drop valid
  task automatic send(input logic [3:0] ta, input logic [3:0] tb_v, input logic [3:0] top,
                      output int waited);
    bit got;
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    sel = top;
    waited = 0;
    got = 1'b0;
    while (!got && waited < 40) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else waited++;
    end
    if (got) begin
      exp_q.push_back(model(ta, tb_v, top));
      @(posedge clk);
      #1;
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for 40 cycles, required 1");
    end
    in_valid = 1'b0;
  endtask

  // wait (bounded) for a result, check literals, then consume it with a one-cycle pulse
  task automatic expect_lit(input string name, input logic [7:0] ey, input logic [3:0] ef,
                            output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = n + 1;
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_y"}, 32'(y), 32'(ey));
    check({name, "_flags"}, 32'(flags), 32'(ef));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  function automatic void add_vec(input logic [3:0] va, input logic [3:0] vb,
                                  input logic [3:0] op, input logic [7:0] ey,
                                  input logic [3:0] ef);
    vec_t v;
    v.va = va; v.vb = vb; v.op = op; v.ey = ey; v.ef = ef;
    vt.push_back(v);
  endfunction

  initial begin
    int w, lat, hs0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sel = '0;

    // flags are {V,C,N,Z}
    add_vec(4'h7, 4'h1, 4'h0, 8'h08, 4'b1000);
    add_vec(4'h8, 4'h1, 4'h1, 8'hF7, 4'b1110);
    add_vec(4'h3, 4'h5, 4'h1, 8'hFE, 4'b0010);
    add_vec(4'hF, 4'h1, 4'h0, 8'h00, 4'b0101);
    add_vec(4'h7, 4'h0, 4'h2, 8'h08, 4'b1000);
    add_vec(4'hF, 4'h0, 4'h2, 8'h00, 4'b0101);
    add_vec(4'h8, 4'h0, 4'h3, 8'hF7, 4'b1110);
    add_vec(4'h8, 4'h0, 4'h4, 8'h08, 4'b1000);
    add_vec(4'h0, 4'h0, 4'h4, 8'h00, 4'b0101);
    add_vec(4'h8, 4'h8, 4'h5, 8'h40, 4'b1000);
    add_vec(4'h3, 4'hE, 4'h5, 8'hFA, 4'b0010);
    add_vec(4'h7, 4'h7, 4'h5, 8'h31, 4'b1000);
    add_vec(4'h5, 4'h3, 4'h6, 8'h28, 4'b0000);
    add_vec(4'hF, 4'h3, 4'h6, 8'hF8, 4'b0010);
    add_vec(4'h8, 4'h2, 4'h7, 8'hFE, 4'b0010);
    add_vec(4'h5, 4'h1, 4'h7, 8'h02, 4'b0000);
    add_vec(4'h5, 4'h0, 4'h8, 8'hFA, 4'b0010);
    add_vec(4'h0, 4'h0, 4'h9, 8'hFF, 4'b0010);
    add_vec(4'hC, 4'hA, 4'hA, 8'hF8, 4'b0010);
    add_vec(4'h3, 4'h4, 4'hB, 8'h07, 4'b0000);
    add_vec(4'h5, 4'h5, 4'hC, 8'h00, 4'b0001);
    add_vec(4'h5, 4'h5, 4'hD, 8'hFF, 4'b0010);
    add_vec(4'hF, 4'hF, 4'hE, 8'h00, 4'b0001);
    add_vec(4'h0, 4'h0, 4'hF, 8'hFF, 4'b0010);

    // reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // directed table with literal results and latency
    foreach (vt[i]) begin
      send(vt[i].va, vt[i].vb, vt[i].op, w);
      expect_lit($sformatf("vec%0d", i), vt[i].ey, vt[i].ef, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), (vt[i].op == 4'h5) ? 32'd5 : 32'd1);
    end

    // backpressure: result held for 10 cycles, then accept-in-same-cycle
    send(4'h3, 4'h2, 4'h0, w);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_y", 32'(y), 32'h05);
      check("bp_flags", 32'(flags), 32'b0000);
    end
    out_ready = 1'b1;
    send(4'h2, 4'h5, 4'h1, w);
    out_ready = 1'b0;
    check("bp_same_cycle_accept", 32'(w), 32'd0);
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_y", 32'(y), 32'hFD);
    check("bp_next_flags", 32'(flags), 32'b0010);
    expect_lit("bp_drain", 8'hFD, 4'b0010, lat);

    // stream of 8 non-mul beats with out_ready held high
    out_ready = 1'b1;
    hs0 = n_hs;
    for (int i = 0; i < 8; i++) begin
      send(vt[i].va, vt[i].vb, vt[i].op, w);
      check("stream_no_stall", 32'(w), 32'd0);
    end
    @(posedge clk);
    #1;
    check("stream_results", 32'(n_hs - hs0), 32'd8);
    check("stream_idle_after", 32'(out_valid), 32'd0);

    // reset in the second multiply cycle
    send(4'h7, 4'h7, 4'h5, w);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_y", 32'(y), 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("abort_in_ready_after", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_stale", 32'(out_valid), 32'd0);
    end
    send(4'h1, 4'h2, 4'h0, w);
    expect_lit("abort_fresh_add", 8'h03, 4'b0000, lat);
    check("abort_fresh_latency", 32'(lat), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
